// File: rtl/step_controller.sv
// Debounced single-step / free-run clock-enable generator with stretched core reset.
// Define STEP_COUNTER_EN to implement the step_count counter; otherwise step_count is tied to 0.
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 12_500_000,
    parameter int CNT_W           = 16,
    parameter int RST_STRETCH     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_key_n,
    input  logic             rst_key_n,
    input  logic             run_sw,
    input  logic             halt,
    output logic             step_en,
    output logic             cpu_reset,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam int STR_W = $clog2(RST_STRETCH + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_e;

    // Bit order in the synchronizer vectors: {run_sw, rst_key_n, step_key_n}.
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    logic key_pressed;
    logic rst_key_released;
    logic run_mode;

    deb_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_evt;

    logic [STR_W-1:0] str_cnt_q, str_cnt_d;
    logic             cpu_reset_q, cpu_reset_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic             step_en_q, step_en_d;

    assign key_pressed      = ~sync_q[0];
    assign rst_key_released = sync_q[1];
    assign run_mode         = sync_q[2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            str_cnt_q   <= '0;
            cpu_reset_q <= 1'b1;
            div_q       <= '0;
            step_en_q   <= 1'b0;
        end else begin
            meta_q      <= {run_sw, rst_key_n, step_key_n};
            sync_q      <= meta_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            str_cnt_q   <= str_cnt_d;
            cpu_reset_q <= cpu_reset_d;
            div_q       <= div_d;
            step_en_q   <= step_en_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_pressed) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_pressed) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = PRESSED;
                    press_evt = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (!key_pressed) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_pressed) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Core reset follows the synced key, then lingers RST_STRETCH cycles after release.
    always_comb begin
        cpu_reset_d = cpu_reset_q;
        str_cnt_d   = str_cnt_q;
        if (!rst_key_released) begin
            cpu_reset_d = 1'b1;
            str_cnt_d   = '0;
        end else if (cpu_reset_q) begin
            if (str_cnt_q == STR_LAST) begin
                cpu_reset_d = 1'b0;
            end else begin
                str_cnt_d = str_cnt_q + STR_W'(1);
            end
        end
    end

    // The divider idles at zero outside run mode, so entering run mode always restarts the period.
    always_comb begin
        div_d     = div_q;
        step_en_d = 1'b0;
        if (cpu_reset_q || !run_mode) begin
            div_d = '0;
        end
        if (!cpu_reset_q && !halt) begin
            if (run_mode) begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    step_en_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end else begin
                step_en_d = press_evt;
            end
        end
    end

`ifdef STEP_COUNTER_EN
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (cpu_reset_q) begin
            step_cnt_d = '0;
        end else if (step_en_q) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_count = step_cnt_q;
`else
    assign step_count = '0;
`endif

    assign step_en   = step_en_q;
    assign cpu_reset = cpu_reset_q;
    assign running   = run_mode & ~halt & ~cpu_reset_q;

endmodule
